// File: rtl/solver_sequencer.sv
// Iterative solver sequencer: loads operands, steps through NUM_STAGES compute
// stages per iteration, repeats while continue_while holds (bounded by max_iter),
// then presents a result until acknowledged.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             leave IDLE and begin operand loading
//   sel               operand load requests, lowest index wins
//   ready             operands loaded, begin computing
//   stage_done        current stage complete
//   continue_while    loop condition, sampled on last-stage completion
//   max_iter          iteration limit, 0 = unlimited
//   abort             cancel the run (LOAD/COMPUTE only)
//   ack               consumer accepted the result
//   load_en           registered one-hot operand register enables
//   stage_idx         current stage number
//   stage_start       one-cycle pulse at the start of each stage
//   iter_count        completed iterations
//   busy, valid       decoded from state (LOAD/COMPUTE, DONE)
//   limit_hit         run ended because max_iter was reached
//   state             IDLE=0, LOAD=1, COMPUTE=2, DONE=3
module solver_sequencer #(
   parameter int unsigned NUM_OPS    = 4,
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned ITER_W     = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [NUM_OPS-1:0]              sel,
   input  logic                            ready,
   input  logic                            stage_done,
   input  logic                            continue_while,
   input  logic [ITER_W-1:0]               max_iter,
   input  logic                            abort,
   input  logic                            ack,
   output logic [NUM_OPS-1:0]              load_en,
   output logic [$clog2(NUM_STAGES)-1:0]   stage_idx,
   output logic                            stage_start,
   output logic [ITER_W-1:0]               iter_count,
   output logic                            busy,
   output logic                            valid,
   output logic                            limit_hit,
   output logic [1:0]                      state
);

   localparam int unsigned SW = $clog2(NUM_STAGES);
   localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_OPS-1:0]  load_en_d;
   logic [SW-1:0]       stage_idx_d;
   logic                stage_start_d;
   logic [ITER_W-1:0]   iter_count_d;
   logic                limit_hit_d;
   logic [ITER_W-1:0]   iter_inc;
   logic [NUM_OPS-1:0]  sel_lowest;

   // Isolate the lowest set request bit (zero when no request).
   assign sel_lowest = sel & (~sel + NUM_OPS'(1));
   assign iter_inc   = iter_count + ITER_W'(1);

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         load_en     <= '0;
         stage_idx   <= '0;
         stage_start <= 1'b0;
         iter_count  <= '0;
         limit_hit   <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_en     <= load_en_d;
         stage_idx   <= stage_idx_d;
         stage_start <= stage_start_d;
         iter_count  <= iter_count_d;
         limit_hit   <= limit_hit_d;
      end
   end

   // Next-state and next-output logic; abort outranks ready and stage_done.
   always_comb begin
      state_d       = state_q;
      load_en_d     = '0;
      stage_idx_d   = stage_idx;
      stage_start_d = 1'b0;
      iter_count_d  = iter_count;
      limit_hit_d   = limit_hit;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = LOAD;
               iter_count_d = '0;
               limit_hit_d  = 1'b0;
            end
         end
         LOAD: begin
            if (abort) begin
               state_d     = IDLE;
               stage_idx_d = '0;
            end else if (ready) begin
               state_d       = COMPUTE;
               stage_idx_d   = '0;
               stage_start_d = 1'b1;
            end else begin
               load_en_d = sel_lowest;
            end
         end
         COMPUTE: begin
            if (abort) begin
               state_d     = IDLE;
               stage_idx_d = '0;
            end else if (stage_done) begin
               if (stage_idx != LAST_STAGE) begin
                  stage_idx_d   = stage_idx + SW'(1);
                  stage_start_d = 1'b1;
               end else begin
                  iter_count_d = iter_inc;
                  if (!continue_while) begin
                     state_d = DONE;
                  end else if ((max_iter != '0) && (iter_inc == max_iter)) begin
                     state_d     = DONE;
                     limit_hit_d = 1'b1;
                  end else begin
                     stage_idx_d   = '0;
                     stage_start_d = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            if (ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign state = state_q;
   assign busy  = (state_q == LOAD) || (state_q == COMPUTE);
   assign valid = (state_q == DONE);

endmodule
